// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Branch-predictor shared definitions. Holds the branch-kind
//                encoding used by the predict stage, the global-history
//                checkpoint manager and the EX branch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int c_KIND_W = 3;

    typedef logic [c_KIND_W-1:0] br_kind_t;

    localparam br_kind_t c_NOT_JUMP      = 3'd0;
    localparam br_kind_t c_DIRECT_JUMP   = 3'd1;  // conditional branch
    localparam br_kind_t c_RET           = 3'd4;
    localparam br_kind_t c_INDIRECT_JUMP = 3'd5;
    localparam br_kind_t c_CALL          = 3'd6;
    localparam br_kind_t c_JUMP          = 3'd7;

    // Any control-transfer kind occupies a checkpoint slot.
    function automatic logic is_branch(input br_kind_t kind);
        return kind != c_NOT_JUMP;
    endfunction

    // Only conditional branches contribute a direction bit to the history.
    function automatic logic is_conditional(input br_kind_t kind);
        return kind == c_DIRECT_JUMP;
    endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/hist_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hist_fifo
//  Description : In-order checkpoint storage for global-history snapshots.
//                Push writes the tail, pop retires the head, clear empties
//                the queue (clear wins over push/pop). The head entry is
//                presented combinationally.
//  Ports       : clk, rstn       - clock, async active-low reset
//                push, push_data - write a checkpoint at the tail
//                pop             - retire the head entry
//                clear           - drop every entry
//                head_data       - oldest entry (valid when count != 0)
//                count           - number of entries, PTR_W+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module hist_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !clear;
    assign w_pop  = pop  && !clear;

    // Pointers wrap naturally because DEPTH is a power of two; the extra
    // count bit tells full from empty when the pointers coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Every entry is cleared on reset so the head read is a defined zero
    // straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : hist_fifo
`default_nettype wire

// File: rtl/ghr_checkpoint.sv
`default_nettype none
// ============================================================================
//  Module      : ghr_checkpoint
//  Description : Speculative global-history manager. Shifts predicted
//                conditional outcomes into gh, checkpoints the pre-shift
//                history of every in-flight branch, hands the oldest one to
//                EX as gh_ex, and restores gh on mispredict or flush.
//  Ports       : clk, rstn                 - clock, async active-low reset
//                pdc_valid/kind_pdc/taken_pdc - predict-stage branch info
//                pdc_ready                 - a checkpoint slot is free
//                gh                        - speculative history
//                ex_valid/kind_ex/taken_real/mispredict_ex - EX resolve
//                gh_ex, ex_hit             - oldest checkpoint and its valid
//                flush_all                 - exception/ertn flush
//                err                       - sticky resolve-on-empty flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ghr_checkpoint
    import bp_pkg::*;
#(
    parameter int gh_width = 32,
    parameter int DEPTH    = 8,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pdc_valid,
    input  logic [2:0]          kind_pdc,
    input  logic                taken_pdc,
    output logic                pdc_ready,
    output logic [gh_width-1:0] gh,
    input  logic                ex_valid,
    input  logic [2:0]          kind_ex,
    input  logic                taken_real,
    input  logic                mispredict_ex,
    output logic [gh_width-1:0] gh_ex,
    output logic                ex_hit,
    input  logic                flush_all,
    output logic                err
);

    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [gh_width-1:0] r_gh;
    logic [gh_width-1:0] r_gh_arch;
    logic                r_err;

    logic [gh_width-1:0] w_head;
    logic [PTR_W:0]      w_count;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_resolve_empty;
    logic                w_mis_recover;
    logic                w_clear;
    logic [gh_width-1:0] w_restored;
    logic [gh_width-1:0] w_gh_arch_next;
    logic [gh_width-1:0] w_gh_next;

    // Slot availability looks only at the registered count: a pop in the
    // same cycle does not make room for a push until the next cycle.
    assign pdc_ready = (w_count < c_DEPTH_CNT);
    assign ex_hit    = (w_count != '0);

    assign w_push_req      = pdc_valid && is_branch(kind_pdc) && pdc_ready;
    assign w_pop           = ex_valid  && is_branch(kind_ex)  && ex_hit;
    assign w_resolve_empty = ex_valid  && is_branch(kind_ex)  && !ex_hit;
    assign w_mis_recover   = w_pop && mispredict_ex;

    // Either recovery empties the FIFO; anything predicted this cycle is on
    // the wrong path and must not be checkpointed.
    assign w_clear = flush_all || w_mis_recover;
    assign w_push  = w_push_req && !w_clear;

    // The head holds the pre-shift history, so a conditional branch gets its
    // real outcome appended to rebuild the post-branch history.
    assign w_restored = is_conditional(kind_ex) ? {w_head[gh_width-2:0], taken_real}
                                                : w_head;

    assign w_gh_arch_next = w_pop ? w_restored : r_gh_arch;

    always_comb begin
        w_gh_next = r_gh;
        if (flush_all) begin
            // Flush returns to the committed history including any retire
            // happening in this same cycle.
            w_gh_next = w_gh_arch_next;
        end else if (w_mis_recover) begin
            w_gh_next = w_restored;
        end else if (w_push && is_conditional(kind_pdc)) begin
            w_gh_next = {r_gh[gh_width-2:0], taken_pdc};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gh      <= '0;
            r_gh_arch <= '0;
            r_err     <= 1'b0;
        end else begin
            r_gh      <= w_gh_next;
            r_gh_arch <= w_gh_arch_next;
            if (w_resolve_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    hist_fifo #(
        .WIDTH (gh_width),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_hist_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (r_gh),
        .pop       (w_pop),
        .clear     (w_clear),
        .head_data (w_head),
        .count     (w_count)
    );

    assign gh    = r_gh;
    assign gh_ex = w_head;
    assign err   = r_err;

endmodule : ghr_checkpoint
`default_nettype wire

// File: tb/tb_ghr_checkpoint.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghr_checkpoint
//  Description : Self-checking bench for ghr_checkpoint. Directed scenarios
//                followed by randomized traffic, compared against a
//                queue-based reference model of the history manager.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ghr_checkpoint;

    localparam int c_GHW   = 32;
    localparam int c_DEPTH = 8;

    logic              clk;
    logic              rstn;
    logic              pdc_valid;
    logic [2:0]        kind_pdc;
    logic              taken_pdc;
    logic              pdc_ready;
    logic [c_GHW-1:0]  gh;
    logic              ex_valid;
    logic [2:0]        kind_ex;
    logic              taken_real;
    logic              mispredict_ex;
    logic [c_GHW-1:0]  gh_ex;
    logic              ex_hit;
    logic              flush_all;
    logic              err;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [c_GHW-1:0] m_gh;
    logic [c_GHW-1:0] m_arch;
    logic             m_err;
    logic [c_GHW-1:0] m_q[$];

    ghr_checkpoint #(
        .gh_width (c_GHW),
        .DEPTH    (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pdc_valid     (pdc_valid),
        .kind_pdc      (kind_pdc),
        .taken_pdc     (taken_pdc),
        .pdc_ready     (pdc_ready),
        .gh            (gh),
        .ex_valid      (ex_valid),
        .kind_ex       (kind_ex),
        .taken_real    (taken_real),
        .mispredict_ex (mispredict_ex),
        .gh_ex         (gh_ex),
        .ex_hit        (ex_hit),
        .flush_all     (flush_all),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_GHW-1:0] obs,
                         input logic [c_GHW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gh   = '0;
        m_arch = '0;
        m_err  = 1'b0;
        m_q.delete();
    endtask

    // Compare all visible outputs against the model.
    task automatic check_all(input string tag);
        check({tag, ".gh"},        gh,        m_gh);
        check({tag, ".ex_hit"},    c_GHW'(ex_hit),    c_GHW'(m_q.size() != 0));
        check({tag, ".pdc_ready"}, c_GHW'(pdc_ready), c_GHW'(m_q.size() < c_DEPTH));
        check({tag, ".err"},       c_GHW'(err),       c_GHW'(m_err));
        if (m_q.size() != 0) begin
            check({tag, ".gh_ex"}, gh_ex, m_q[0]);
        end
    endtask

    // Apply the current inputs to the model (one clock of behaviour).
    task automatic model_step();
        logic             br_pdc, br_ex, can_push, can_pop;
        logic [c_GHW-1:0] restored, arch_n, snap;
        br_pdc   = pdc_valid && (kind_pdc != 3'd0);
        br_ex    = ex_valid  && (kind_ex  != 3'd0);
        can_push = br_pdc && (m_q.size() < c_DEPTH);
        can_pop  = br_ex  && (m_q.size() > 0);
        if (br_ex && m_q.size() == 0) m_err = 1'b1;
        restored = '0;
        if (can_pop) begin
            restored = (kind_ex == 3'd1) ? ((m_q[0] << 1) | c_GHW'(taken_real)) : m_q[0];
        end
        arch_n = can_pop ? restored : m_arch;
        if (flush_all) begin
            m_gh = arch_n;
            m_q.delete();
        end else if (can_pop && mispredict_ex) begin
            m_gh = restored;
            m_q.delete();
        end else begin
            if (can_pop) void'(m_q.pop_front());
            if (can_push) begin
                snap = m_gh;
                m_q.push_back(snap);
                if (kind_pdc == 3'd1) m_gh = (m_gh << 1) | c_GHW'(taken_pdc);
            end
        end
        m_arch = arch_n;
    endtask

    // Drive one cycle of stimulus from the negative edge, advance, check.
    task automatic cycle(input logic pv, input logic [2:0] kp, input logic tp,
                         input logic ev, input logic [2:0] ke, input logic tr,
                         input logic mis, input logic fl, input string tag);
        pdc_valid     = pv;
        kind_pdc      = kp;
        taken_pdc     = tp;
        ex_valid      = ev;
        kind_ex       = ke;
        taken_real    = tr;
        mispredict_ex = mis;
        flush_all     = fl;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    function automatic logic [2:0] rand_kind();
        logic [2:0] kinds [6];
        kinds = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        // Favour conditional branches so the history actually moves.
        if ($urandom_range(0, 1) == 0) return 3'd1;
        return kinds[$urandom_range(0, 5)];
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn = 1'b0;
        pdc_valid = 1'b0; kind_pdc = 3'd0; taken_pdc = 1'b0;
        ex_valid = 1'b0; kind_ex = 3'd0; taken_real = 1'b0;
        mispredict_ex = 1'b0; flush_all = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_gh_ex", gh_ex, '0);
        check_all("rst");
        rstn = 1'b1;
        @(negedge clk);

        // Three conditional pushes: taken 1,0,1
        cycle(1, 3'd1, 1, 0, 3'd0, 0, 0, 0, "p1");
        cycle(1, 3'd1, 0, 0, 3'd0, 0, 0, 0, "p2");
        cycle(1, 3'd1, 1, 0, 3'd0, 0, 0, 0, "p3");
        check("tp1_gh", gh, 32'h5);
        check("tp1_gh_ex", gh_ex, 32'h0);
        check("tp1_hit", c_GHW'(ex_hit), 32'h1);

        // CALL leaves the history alone
        cycle(1, 3'd6, 1, 0, 3'd0, 0, 0, 0, "call");
        check("tp2_gh", gh, 32'h5);

        // Mispredicted pop with a same-cycle push that must be dropped
        cycle(1, 3'd1, 1, 1, 3'd1, 0, 1, 0, "mis");
        check("tp3_gh", gh, 32'h0);
        check("tp3_hit", c_GHW'(ex_hit), 32'h0);

        // Fill eight conditional taken branches
        for (int i = 0; i < c_DEPTH; i++) cycle(1, 3'd1, 1, 0, 3'd0, 0, 0, 0, "fill");
        check("tp4_full", c_GHW'(pdc_ready), 32'h0);
        check("tp4_gh", gh, 32'hFF);
        // Push while full with a correct pop in the same cycle: push dropped
        cycle(1, 3'd1, 1, 1, 3'd1, 1, 0, 0, "fullpop");
        check("tp4_ready", c_GHW'(pdc_ready), 32'h1);
        check("tp4_gh_ex", gh_ex, 32'h1);
        check("tp4_gh_keep", gh, 32'hFF);

        // Correct pop takes gh_arch to 0x3, then flush with a pop -> 0x7
        cycle(0, 3'd0, 0, 1, 3'd1, 1, 0, 0, "pop2");
        cycle(1, 3'd1, 0, 1, 3'd1, 1, 0, 1, "flush");
        check("tp5_gh", gh, 32'h7);
        check("tp5_hit", c_GHW'(ex_hit), 32'h0);

        // Resolve on empty FIFO: sticky err, history unchanged
        cycle(0, 3'd0, 0, 1, 3'd1, 1, 1, 0, "empty");
        check("tp6_err", c_GHW'(err), 32'h1);
        check("tp6_gh", gh, 32'h7);
        idle("hold");
        check("tp6_err_hold", c_GHW'(err), 32'h1);

        // Randomized traffic; pop rate alternates so the FIFO both fills and drains
        for (int i = 0; i < 2000; i++) begin
            logic busy_ex;
            busy_ex = ((i / 100) % 2) == 1;
            cycle($urandom_range(0, 3) != 0, rand_kind(), 1'($urandom),
                  busy_ex ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
                  rand_kind(), 1'($urandom),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0, "rnd");
        end

        // Build up state, then assert reset between clock edges
        for (int i = 0; i < 5; i++) cycle(1, 3'd1, 1, 0, 3'd0, 0, 0, 0, "pre");
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check("mid_rst_gh_ex", gh_ex, '0);
        check_all("mid_rst");
        @(negedge clk);
        rstn = 1'b1;
        cycle(1, 3'd1, 1, 0, 3'd0, 0, 0, 0, "post");
        check("post_gh", gh, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ghr_checkpoint
`default_nettype wire

// File: doc/ghr_checkpoint.md
# ghr_checkpoint

Speculative global-history manager sitting directly upstream of the direction predictor. It holds the global history `gh` presented to the TAGE/BHT predictor each fetch cycle and shifts in each predicted conditional-branch outcome. It checkpoints the pre-shift history of every in-flight branch in an in-order FIFO and supplies that history as `gh_ex` when the branch resolves in EX. On an EX mispredict or a pipeline flush it restores the correct history.

## Interface
Parameters:
- `gh_width`, 32, global history length in bits.
- `DEPTH`, 8, checkpoint FIFO entries; power of two, at least 2.
- `PTR_W`, $clog2(DEPTH), FIFO pointer width.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pdc_valid`  in  1  predict stage has an instruction this cycle.
- `kind_pdc`  in  3  branch kind of the predicted instruction.
- `taken_pdc`  in  1  predicted direction.
- `pdc_ready`  out  1  FIFO can accept a checkpoint.
- `gh`  out  gh_width  speculative history for the current prediction.
- `ex_valid`  in  1  a branch is resolving in EX.
- `kind_ex`  in  3  kind of the resolving instruction.
- `taken_real`  in  1  resolved direction.
- `mispredict_ex`  in  1  resolving branch was mispredicted (direction or target).
- `gh_ex`  out  gh_width  checkpointed history of the oldest in-flight branch.
- `ex_hit`  out  1  FIFO non-empty, so `gh_ex` is valid.
- `flush_all`  in  1  exception/ertn flush.
- `err`  out  1  sticky flag: resolve with empty FIFO.

## Operation
- Kind codes: NOT_JUMP=0, DIRECT_JUMP=1 (conditional), RET=4, INDIRECT_JUMP=5, CALL=6, JUMP=7.
- push = `pdc_valid && kind_pdc!=0 && pdc_ready`. It writes the current `gh` to the tail.
- On push with kind 1, `gh` ← {gh[gh_width-2:0], taken_pdc}. Other kinds leave `gh` unchanged.
- pop = `ex_valid && kind_ex!=0 && ex_hit`. It removes the head entry.
- restored = kind_ex==1 ? {head[gh_width-2:0], taken_real} : head.
- Every pop writes the architectural register `gh_arch` ← restored.
- Pop with `mispredict_ex`:
  - `gh` ← restored.
  - FIFO cleared.
  - A same-cycle push is dropped because it is on the wrong path.
- `ex_valid && kind_ex!=0 && !ex_hit` sets `err`. `gh`, `gh_arch` and the FIFO are unchanged. `err` is cleared only by reset.
- `flush_all`:
  - `gh` ← `gh_arch` next value, i.e. including any same-cycle pop.
  - FIFO cleared and same-cycle push dropped.
  - Priority over mispredict.
- `pdc_ready` = count<DEPTH, computed from the registered count. A same-cycle pop does not free a slot for this cycle.
- Push and pop in the same cycle without mispredict or flush: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. The full/empty distinction comes from a count of width PTR_W+1.

## Timing
- Reset values:
  - `gh`=0, `gh_arch`=0.
  - count=0, pointers=0.
  - `pdc_ready`=1, `ex_hit`=0, `gh_ex`=0 (entry 0 cleared), `err`=0.
- `gh` is registered. A push in cycle t is visible in `gh` at t+1.
- `gh_ex` and `ex_hit` are combinational reads of registered head state. They are valid in the same cycle as `ex_valid`.
- Recovery from mispredict or flush in cycle t: `gh` is correct at t+1, and `pdc_ready`=1 at t+1.
- Reset asserted mid-operation returns all state to reset values immediately. No partial FIFO survives.

## Structure
- Shared package `bp_pkg` holds the branch-kind constants, reused by the predictor and the EX branch unit.
- Sub-module `hist_fifo` provides parameterised storage with push, pop, clear, count, and a head read port.
- The top level contains the shift/restore datapath, the priority logic and `err`.

## Test plan
- Reset, then push 3× kind 1 with taken=1,0,1 → `gh`=0x5, FIFO entries 0x0,0x1,0x2, `ex_hit`=1, `gh_ex`=0x0.
- Push kind 6 (CALL) with `gh`=0x5 → `gh` stays 0x5, count +1.
- From the first scenario, pop kind 1 with taken_real=0 and mispredict → next cycle `gh`=0x0, `gh_arch`=0x0, count=0. A same-cycle push is dropped.
- Fill 8 entries → `pdc_ready`=0. A push with pop in that cycle is dropped. Next cycle `pdc_ready`=1, count=7.
- Correct pops advance `gh_arch` to 0x3. Then `flush_all` together with a pop of kind 1, taken_real=1 → `gh`=0x7, FIFO empty.
- `ex_valid` with kind 1 and an empty FIFO → `err`=1 and stays 1, `gh` unchanged. Assert `rstn` low mid-stream → all outputs at reset values immediately.
